dp_grant_sched: RTL

- Request-collection and grant-sequencing stage wrapped around the dual-priority encoder.
- Latches incoming request pulses into a sticky 12-bit pending vector, which drives the encoder's req input.
- Snapshots the encoder's first/second codes and issues them as up to two sequential grants over a valid/ready handshake.
- Clears each pending bit when its grant is accepted, so the encoder then presents the next-highest pair.

---
 rtl/dp_grant_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dp_grant_sched.sv
// Purpose : collects request pulses into a sticky pending vector and issues the dual-priority encoder's top two codes as sequential grants.
// Latency : request at edge k shows in pend after k; first grant offered after edge k+1; one IDLE cycle separates consecutive pairs.
// Backpr. : valid/ready grant; gnt_code/gnt_last hold while gnt_ready=0 (optional watchdog abandons a stalled grant).
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req_in          request pulses/levels, bit i requests code i+1
//   pend            registered pending vector, drives encoder req
//   first, second   encoder top-two codes of pend (0 = none, >REQ_W ignored)
//   gnt_valid/gnt_code/gnt_last/gnt_ready   grant handshake
//   busy            pair in progress
//   timeout         watchdog expiry pulse (only with DP_SCHED_TIMEOUT_EN)
//
// Build option: define DP_SCHED_TIMEOUT_EN to add the grant watchdog and the
// timeout port; TIMEOUT is only used in that build.
module dp_grant_sched #(
    parameter int REQ_W   = 12,
    parameter int CODE_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  req_in,
    output logic [REQ_W-1:0]  pend,
    input  logic [CODE_W-1:0] first,
    input  logic [CODE_W-1:0] second,
    output logic              gnt_valid,
    output logic [CODE_W-1:0] gnt_code,
    output logic              gnt_last,
    input  logic              gnt_ready,
    output logic              busy
`ifdef DP_SCHED_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(REQ_W);

    state_t            state, state_nxt;
    logic [REQ_W-1:0]  pend_nxt;
    logic [REQ_W-1:0]  clr_mask;
    logic [CODE_W-1:0] snap1, snap2;
    logic [CODE_W-1:0] snap1_nxt, snap2_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              vld_nxt, last_nxt;
    logic              xfer;
    logic              first_ok, second_ok;

`ifdef DP_SCHED_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wdog, wdog_nxt;
    logic       timeout_nxt;
`endif

    // Codes outside 1..REQ_W from the encoder are treated as "none".
    assign first_ok  = (first  != '0) && (first  <= MAX_CODE);
    assign second_ok = (second != '0) && (second <= MAX_CODE);
    assign xfer      = gnt_valid && gnt_ready;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            snap1     <= '0;
            snap2     <= '0;
            gnt_valid <= 1'b0;
            gnt_code  <= '0;
            gnt_last  <= 1'b0;
`ifdef DP_SCHED_TIMEOUT_EN
            wdog      <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            snap1     <= snap1_nxt;
            snap2     <= snap2_nxt;
            gnt_valid <= vld_nxt;
            gnt_code  <= code_nxt;
            gnt_last  <= last_nxt;
`ifdef DP_SCHED_TIMEOUT_EN
            wdog      <= wdog_nxt;
            timeout   <= timeout_nxt;
`endif
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt = state;
        snap1_nxt = snap1;
        snap2_nxt = snap2;
        vld_nxt   = gnt_valid;
        code_nxt  = gnt_code;
        last_nxt  = gnt_last;
        clr_mask  = '0;
`ifdef DP_SCHED_TIMEOUT_EN
        wdog_nxt    = '0;
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Snapshot the pair; it stays fixed until both grants finish.
                if ((pend != '0) && first_ok) begin
                    snap1_nxt = first;
                    snap2_nxt = second_ok ? second : '0;
                    code_nxt  = first;
                    vld_nxt   = 1'b1;
                    last_nxt  = !second_ok;
                    state_nxt = GNT1;
                end
            end
            GNT1, GNT2: begin
                if (xfer) begin
                    clr_mask = REQ_W'(1) << ((state == GNT1) ? (snap1 - CODE_W'(1))
                                                             : (snap2 - CODE_W'(1)));
                    if ((state == GNT1) && (snap2 != '0)) begin
                        code_nxt  = snap2;
                        last_nxt  = 1'b1;
                        state_nxt = GNT2;
                    end else begin
                        vld_nxt   = 1'b0;
                        code_nxt  = '0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
`ifdef DP_SCHED_TIMEOUT_EN
                // Stalled grant: abandon it at the limit, leaving its bit pending.
                else if (wdog == WDOG_LAST) begin
                    vld_nxt     = 1'b0;
                    code_nxt    = '0;
                    last_nxt    = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    wdog_nxt = wdog + 8'd1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
                code_nxt  = '0;
                last_nxt  = 1'b0;
            end
        endcase
        // Set wins over clear on the same bit.
        pend_nxt = (pend & ~clr_mask) | req_in;
    end

    // Outputs derived from state.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule
